// File: rtl/mmio_rd_sched_pkg.sv
// Shared types and constants for the MMIO read scheduler and its optional
// timeout helper.
package mmio_rd_sched_pkg;

   localparam int TAG_W      = 10;
   localparam int LEN_W      = 14;
   localparam int REQID_W    = 16;
   localparam int LOW_ADDR_W = 24;
   localparam int CNT_W      = 8;
   localparam int ADDR_MAX_W = 64;

   // Wide enough for any supported readdata width; users slice the low bits.
   localparam logic [1023:0] ALL_ONES_RSP = '1;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } rd_state_e;

   typedef struct packed {
      logic [ADDR_MAX_W-1:0] addr;
      logic [TAG_W-1:0]      tag;
      logic [LEN_W-1:0]      length;
      logic [REQID_W-1:0]    req_id;
   } rd_req_t;

endpackage

// File: rtl/mmio_rd_timeout.sv
// Read-timeout helper: watchdog timer, discard counter for late responses and
// the synthetic-completion strobe. Only instantiated under MMIO_RD_TIMEOUT_EN.
module mmio_rd_timeout
   import mmio_rd_sched_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] outstanding_i,
   input  logic             rdv_i,
   output logic [CNT_W-1:0] discard_cnt_o,
   output logic             expire_o
);

   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic             expire;

   // Timer runs down from TIMEOUT_CYCLES-1; a real response always wins the
   // expiry cycle.
   always_comb begin
      expire    = (outstanding_i != '0) && (tmr_q == '0) && !rdv_i;
      tmr_d     = tmr_q - 1'b1;
      discard_d = discard_q;
      if (rdv_i || (outstanding_i == '0) || expire) begin
         tmr_d = TMR_LOAD;
      end
      if (expire) begin
         discard_d = discard_q + 1'b1;
      end else if (rdv_i && (discard_q != '0)) begin
         discard_d = discard_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_q     <= TMR_LOAD;
         discard_q <= '0;
      end else begin
         tmr_q     <= tmr_d;
         discard_q <= discard_d;
      end
   end

   assign discard_cnt_o = discard_q;
   assign expire_o      = expire;

endmodule

// File: rtl/axis_mmio_rd_sched.sv
// MMIO read scheduler: one AVMM read at a time, credit/almost-full throttled
// admission, completion sideband and read-data pass-through.
// Optional synthetic timeout completions under MMIO_RD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an admissible request
// ISSUE | AVMM read asserted until waitrequest drops
module axis_mmio_rd_sched
   import mmio_rd_sched_pkg::*;
#(
   parameter int AVMM_ADDR_WIDTH = 18,
   parameter int AVMM_DATA_WIDTH = 64,
   parameter int MAX_OUTSTANDING = 64,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [AVMM_ADDR_WIDTH-1:0] req_addr,
   input  logic [TAG_W-1:0]           req_tag,
   input  logic [LEN_W-1:0]           req_length,
   input  logic [REQID_W-1:0]         req_req_id,
   input  logic                       rsp_fifo_almfull,
   output logic                       avmm_m2s_read,
   output logic [AVMM_ADDR_WIDTH-1:0] avmm_m2s_address,
   input  logic                       avmm_m2s_waitrequest,
   input  logic                       avmm_s2m_readdatavalid,
   input  logic [AVMM_DATA_WIDTH-1:0] avmm_s2m_readdata,
   output logic                       rd_datavalid_o,
   output logic [AVMM_DATA_WIDTH-1:0] rd_data_o,
   output logic                       tlp_rd_strb,
   output logic [TAG_W-1:0]           tlp_rd_tag,
   output logic [LEN_W-1:0]           tlp_rd_length,
   output logic [REQID_W-1:0]         tlp_rd_req_id,
   output logic [LOW_ADDR_W-1:0]      tlp_rd_low_addr,
   output logic [CNT_W-1:0]           outstanding,
   output logic                       rd_timeout
);

   rd_state_e        state_q, state_d;
   rd_req_t          req_q, req_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] discard_cnt;
   logic [CNT_W:0]   inflight;
   logic             credit_ok;
   logic             accept;
   logic             syn_rsp;
   logic             fwd_rsp;
   logic             unused_addr_hi;

   // Late responses still owed by the slave occupy credits too.
   assign inflight  = {1'b0, outstanding_q} + {1'b0, discard_cnt};
   assign credit_ok = inflight < (CNT_W + 1)'(MAX_OUTSTANDING);

   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      req_ready     = 1'b0;
      accept        = 1'b0;
      avmm_m2s_read = 1'b0;
      tlp_rd_strb   = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = !rst && credit_ok && !rsp_fifo_almfull;
            accept    = req_valid && !rst && credit_ok && !rsp_fifo_almfull;
            if (accept) begin
               req_d.addr   = ADDR_MAX_W'(req_addr);
               req_d.tag    = req_tag;
               req_d.length = req_length;
               req_d.req_id = req_req_id;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            avmm_m2s_read = 1'b1;
            if (!avmm_m2s_waitrequest) begin
               tlp_rd_strb = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MMIO_RD_TIMEOUT_EN
   mmio_rd_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk           (clk),
      .rst           (rst),
      .outstanding_i (outstanding_q),
      .rdv_i         (avmm_s2m_readdatavalid),
      .discard_cnt_o (discard_cnt),
      .expire_o      (syn_rsp)
   );
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign discard_cnt = '0;
   assign syn_rsp     = 1'b0;
`endif

   assign fwd_rsp        = avmm_s2m_readdatavalid && (discard_cnt == '0);
   assign rd_datavalid_o = fwd_rsp || syn_rsp;
   assign rd_data_o      = syn_rsp ? ALL_ONES_RSP[AVMM_DATA_WIDTH-1:0]
                                   : avmm_s2m_readdata;
   assign rd_timeout     = syn_rsp;

   assign outstanding_d = outstanding_q + {{(CNT_W-1){1'b0}}, tlp_rd_strb}
                                        - {{(CNT_W-1){1'b0}}, rd_datavalid_o};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         req_q         <= '0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign avmm_m2s_address = {req_q.addr[AVMM_ADDR_WIDTH-1:3], 3'b000};
   assign tlp_rd_tag       = req_q.tag;
   assign tlp_rd_length    = req_q.length;
   assign tlp_rd_req_id    = req_q.req_id;
   assign tlp_rd_low_addr  = {{(LOW_ADDR_W-7){1'b0}}, req_q.addr[6:0]};
   assign outstanding      = outstanding_q;
   assign unused_addr_hi   = |(req_q.addr >> AVMM_ADDR_WIDTH);

endmodule

// File: tb/tb_axis_mmio_rd_sched.sv
// Directed bench for axis_mmio_rd_sched: per-cycle behavioural model check plus
// hand-computed expectations for each scenario.
module tb_axis_mmio_rd_sched;

   localparam int AW   = 18;
   localparam int DW   = 64;
   localparam int MAXO = 4;
   localparam int TMO  = 16;
`ifdef MMIO_RD_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [9:0]    req_tag = '0;
   logic [13:0]   req_length = '0;
   logic [15:0]   req_req_id = '0;
   logic          rsp_fifo_almfull = 1'b0;
   logic          avmm_m2s_read;
   logic [AW-1:0] avmm_m2s_address;
   logic          avmm_m2s_waitrequest = 1'b0;
   logic          avmm_s2m_readdatavalid = 1'b0;
   logic [DW-1:0] avmm_s2m_readdata = '0;
   logic          rd_datavalid_o;
   logic [DW-1:0] rd_data_o;
   logic          tlp_rd_strb;
   logic [9:0]    tlp_rd_tag;
   logic [13:0]   tlp_rd_length;
   logic [15:0]   tlp_rd_req_id;
   logic [23:0]   tlp_rd_low_addr;
   logic [7:0]    outstanding;
   logic          rd_timeout;

   always #5 clk = ~clk;

   axis_mmio_rd_sched #(
      .AVMM_ADDR_WIDTH (AW),
      .AVMM_DATA_WIDTH (DW),
      .MAX_OUTSTANDING (MAXO),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .req_valid              (req_valid),
      .req_ready              (req_ready),
      .req_addr               (req_addr),
      .req_tag                (req_tag),
      .req_length             (req_length),
      .req_req_id             (req_req_id),
      .rsp_fifo_almfull       (rsp_fifo_almfull),
      .avmm_m2s_read          (avmm_m2s_read),
      .avmm_m2s_address       (avmm_m2s_address),
      .avmm_m2s_waitrequest   (avmm_m2s_waitrequest),
      .avmm_s2m_readdatavalid (avmm_s2m_readdatavalid),
      .avmm_s2m_readdata      (avmm_s2m_readdata),
      .rd_datavalid_o         (rd_datavalid_o),
      .rd_data_o              (rd_data_o),
      .tlp_rd_strb            (tlp_rd_strb),
      .tlp_rd_tag             (tlp_rd_tag),
      .tlp_rd_length          (tlp_rd_length),
      .tlp_rd_req_id          (tlp_rd_req_id),
      .tlp_rd_low_addr        (tlp_rd_low_addr),
      .outstanding            (outstanding),
      .rd_timeout             (rd_timeout)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a pending (accepted, not yet issued) request, reads in flight,
   // late responses still owed, and cycles waited with no real response.
   bit          m_busy = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [9:0]  m_tag = '0;
   logic [13:0] m_len = '0;
   logic [15:0] m_id = '0;
   int          m_out = 0;
   int          m_disc = 0;
   int          m_age = 0;

   always @(negedge clk) begin
      bit fire, exp_rdy, exp_strb, exp_dv;
      int new_out;
      if (rst) begin
         chk("m_ready_in_reset", 64'(req_ready), 64'd0);
         m_busy = 1'b0;
         m_out  = 0;
         m_disc = 0;
         m_age  = 0;
      end else begin
         fire     = TMO_EN && (m_out > 0) && (m_age == TMO - 1) && !avmm_s2m_readdatavalid;
         exp_rdy  = !m_busy && ((m_out + m_disc) < MAXO) && !rsp_fifo_almfull;
         exp_strb = m_busy && !avmm_m2s_waitrequest;
         exp_dv   = (avmm_s2m_readdatavalid && (m_disc == 0)) || fire;
         chk("m_ready", 64'(req_ready), 64'(exp_rdy));
         chk("m_read", 64'(avmm_m2s_read), 64'(m_busy));
         chk("m_strb", 64'(tlp_rd_strb), 64'(exp_strb));
         chk("m_outstanding", 64'(outstanding), 64'(m_out));
         chk("m_timeout", 64'(rd_timeout), 64'(fire));
         chk("m_datavalid", 64'(rd_datavalid_o), 64'(exp_dv));
         if (m_busy) chk("m_address", 64'(avmm_m2s_address), 64'(m_addr & ~18'h7));
         if (exp_strb) begin
            chk("m_tag", 64'(tlp_rd_tag), 64'(m_tag));
            chk("m_length", 64'(tlp_rd_length), 64'(m_len));
            chk("m_req_id", 64'(tlp_rd_req_id), 64'(m_id));
            chk("m_low_addr", 64'(tlp_rd_low_addr), 64'(m_addr % 128));
         end
         if (exp_dv) chk("m_data", rd_data_o, fire ? 64'hFFFF_FFFF_FFFF_FFFF : avmm_s2m_readdata);
         new_out = m_out + (exp_strb ? 1 : 0) - (exp_dv ? 1 : 0);
         if (fire) m_disc++;
         else if (avmm_s2m_readdatavalid && m_disc > 0) m_disc--;
         if (avmm_s2m_readdatavalid || m_out == 0 || fire) m_age = 0;
         else m_age++;
         m_out = new_out;
         if (exp_strb) m_busy = 1'b0;
         if (exp_rdy && req_valid) begin
            m_busy = 1'b1;
            m_addr = req_addr;
            m_tag  = req_tag;
            m_len  = req_length;
            m_id   = req_req_id;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns at the start of the ISSUE cycle that follows the accept.
   task automatic send(input logic [AW-1:0] a, input logic [9:0] t,
                       input logic [13:0] l, input logic [15:0] id);
      bit got = 1'b0;
      req_addr   = a;
      req_tag    = t;
      req_length = l;
      req_req_id = id;
      req_valid  = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("send_accept", 64'(got), 64'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic respond(input logic [DW-1:0] d);
      avmm_s2m_readdatavalid = 1'b1;
      avmm_s2m_readdata      = d;
      step();
      avmm_s2m_readdatavalid = 1'b0;
      avmm_s2m_readdata      = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_read", 64'(avmm_m2s_read), 64'd0);
      chk("rst_strb", 64'(tlp_rd_strb), 64'd0);
      chk("rst_datavalid", 64'(rd_datavalid_o), 64'd0);
      chk("rst_timeout", 64'(rd_timeout), 64'd0);
      step();
      rst = 1'b0;

      // Single read
      send(18'h1004, 10'h12A, 14'd4, 16'hBEEF);
      @(negedge clk);
      chk("t1_read", 64'(avmm_m2s_read), 64'd1);
      chk("t1_address", 64'(avmm_m2s_address), 64'h1000);
      chk("t1_strb", 64'(tlp_rd_strb), 64'd1);
      chk("t1_low_addr", 64'(tlp_rd_low_addr), 64'h04);
      chk("t1_tag", 64'(tlp_rd_tag), 64'h12A);
      step();
      @(negedge clk);
      chk("t1_outstanding_1", 64'(outstanding), 64'd1);
      step();
      avmm_s2m_readdatavalid = 1'b1;
      avmm_s2m_readdata      = 64'hDEAD;
      @(negedge clk);
      chk("t1_datavalid", 64'(rd_datavalid_o), 64'd1);
      chk("t1_data", rd_data_o, 64'hDEAD);
      step();
      avmm_s2m_readdatavalid = 1'b0;
      avmm_s2m_readdata      = '0;
      @(negedge clk);
      chk("t1_outstanding_0", 64'(outstanding), 64'd0);
      step();

      // waitrequest held for 5 cycles
      avmm_m2s_waitrequest = 1'b1;
      send(18'h2A3F, 10'h055, 14'd8, 16'h0102);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t2_read", 64'(avmm_m2s_read), 64'd1);
         chk("t2_address", 64'(avmm_m2s_address), 64'h2A38);
         chk("t2_ready", 64'(req_ready), 64'd0);
         chk("t2_strb", 64'(tlp_rd_strb), 64'(i == 5));
         step();
         if (i == 4) avmm_m2s_waitrequest = 1'b0;
      end
      respond(64'h0123_4567_89AB_CDEF);

      // Credit limit with a silent slave
      for (int k = 0; k < 4; k++) send(18'(18'h100 + 8 * k), 10'(10'h200 + k), 14'd8, 16'h0300);
      step();
      req_addr   = 18'h3008;
      req_tag    = 10'h204;
      req_length = 14'd8;
      req_req_id = 16'h0300;
      req_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_ready_blocked", 64'(req_ready), 64'd0);
         chk("t3_no_read", 64'(avmm_m2s_read), 64'd0);
         chk("t3_outstanding_4", 64'(outstanding), 64'd4);
         step();
      end
      respond(64'h1111);
      send(18'h3008, 10'h204, 14'd8, 16'h0300);
      @(negedge clk);
      chk("t3_fifth_strb", 64'(tlp_rd_strb), 64'd1);
      step();
      @(negedge clk);
      chk("t3_outstanding_again_4", 64'(outstanding), 64'd4);
      chk("t3_ready_low", 64'(req_ready), 64'd0);
      step();
      for (int k = 0; k < 4; k++) respond(64'(64'h2000 + k));
      @(negedge clk);
      chk("t3_drained", 64'(outstanding), 64'd0);
      step();

      // Response FIFO almost full
      rsp_fifo_almfull = 1'b1;
      req_addr   = 18'h0ABC;
      req_tag    = 10'h3FF;
      req_length = 14'h3FFF;
      req_req_id = 16'hFFFF;
      req_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_ready_almfull", 64'(req_ready), 64'd0);
         chk("t4_no_read", 64'(avmm_m2s_read), 64'd0);
         step();
      end
      rsp_fifo_almfull = 1'b0;
      @(negedge clk);
      chk("t4_ready_released", 64'(req_ready), 64'd1);
      step();
      req_valid        = 1'b0;
      rsp_fifo_almfull = 1'b1;
      @(negedge clk);
      chk("t4_issue_despite_almfull", 64'(tlp_rd_strb), 64'd1);
      chk("t4_address", 64'(avmm_m2s_address), 64'h0AB8);
      step();
      rsp_fifo_almfull = 1'b0;
      respond(64'hCAFE);

`ifdef MMIO_RD_TIMEOUT_EN
      // Timeout with a silent slave, then a late response
      send(18'h0040, 10'h011, 14'd4, 16'h0A0A);
      @(negedge clk);
      chk("t5_strb", 64'(tlp_rd_strb), 64'd1);
      step();
      found = -1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (rd_timeout) begin
            found = k;
            chk("t5_syn_valid", 64'(rd_datavalid_o), 64'd1);
            chk("t5_syn_data", rd_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("t5_outstanding_before", 64'(outstanding), 64'd1);
            break;
         end
         step();
      end
      chk("t5_timeout_cycle", 64'(found), 64'd16);
      step();
      @(negedge clk);
      chk("t5_outstanding_after", 64'(outstanding), 64'd0);
      step();
      avmm_s2m_readdatavalid = 1'b1;
      avmm_s2m_readdata      = 64'h1234;
      @(negedge clk);
      chk("t5_late_dropped", 64'(rd_datavalid_o), 64'd0);
      step();
      avmm_s2m_readdatavalid = 1'b0;
      avmm_s2m_readdata      = '0;
      send(18'h0048, 10'h012, 14'd4, 16'h0A0A);
      step();
      avmm_s2m_readdatavalid = 1'b1;
      avmm_s2m_readdata      = 64'h5555;
      @(negedge clk);
      chk("t5_next_forwarded", 64'(rd_datavalid_o), 64'd1);
      step();
      avmm_s2m_readdatavalid = 1'b0;
      avmm_s2m_readdata      = '0;
`endif

      // Simultaneous issue and response
      send(18'h0100, 10'h001, 14'd8, 16'h0001);
      step();
      send(18'h0108, 10'h002, 14'd8, 16'h0001);
      avmm_s2m_readdatavalid = 1'b1;
      avmm_s2m_readdata      = 64'hA5A5;
      @(negedge clk);
      chk("t6_strb", 64'(tlp_rd_strb), 64'd1);
      chk("t6_datavalid", 64'(rd_datavalid_o), 64'd1);
      step();
      avmm_s2m_readdatavalid = 1'b0;
      avmm_s2m_readdata      = '0;
      @(negedge clk);
      chk("t6_outstanding_same", 64'(outstanding), 64'd1);
      step();
      respond(64'h5A5A);

      // Reset asserted during a stalled ISSUE
      send(18'h0200, 10'h003, 14'd8, 16'h0002);
      step();
      avmm_m2s_waitrequest = 1'b1;
      send(18'h0208, 10'h004, 14'd8, 16'h0002);
      @(negedge clk);
      chk("t7_read_before_rst", 64'(avmm_m2s_read), 64'd1);
      chk("t7_outstanding_before_rst", 64'(outstanding), 64'd1);
      step();
      rst = 1'b1;
      @(negedge clk);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t7_read_after_rst", 64'(avmm_m2s_read), 64'd0);
      chk("t7_outstanding_after_rst", 64'(outstanding), 64'd0);
      step();
      avmm_m2s_waitrequest = 1'b0;

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
